// File: rtl/fetch.sv
// Instruction fetch unit: on an accepted enable pulse, issues one imem read to the
// next (or jump) PC, waits MEM_LATENCY edges, then presents pc/command with a done pulse.
module fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enable,
  input  logic        jump,
  input  logic [31:0] jump_addr,
  output logic        done,
  output logic        busy,
  output logic [31:0] pc,
  output logic [31:0] command,
  output logic [31:0] inst_count,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  localparam logic [2:0] LAT = 3'(MEM_LATENCY);

  state_t      state_r, state_s;
  logic [2:0]  cnt_r;
  logic [31:0] target_r, target_s;
  logic        first_r;
  logic        accept_s, capture_s;

  // Next-state, request acceptance and target selection (jump beats first-fetch).
  always_comb begin
    state_s   = state_r;
    accept_s  = 1'b0;
    capture_s = 1'b0;
    target_s  = pc + 32'd4;
    if (jump) begin
      target_s = {jump_addr[31:2], 2'b00};
    end else if (first_r) begin
      target_s = RESET_PC;
    end else begin
      target_s = pc + 32'd4;
    end
    case (state_r)
      IDLE: begin
        // busy is still high in the done cycle, which blocks a request there
        if (enable && !busy) begin
          accept_s = 1'b1;
          state_s  = WAIT;
        end else begin
          state_s  = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == 3'd0) begin
          capture_s = 1'b1;
          state_s   = IDLE;
        end else begin
          state_s   = WAIT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Registered state, memory strobe and delivered instruction.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r    <= IDLE;
      cnt_r      <= 3'd0;
      target_r   <= 32'd0;
      first_r    <= 1'b1;
      done       <= 1'b0;
      busy       <= 1'b0;
      pc         <= RESET_PC;
      command    <= 32'd0;
      inst_count <= 32'd0;
      imem_en    <= 1'b0;
      imem_addr  <= 32'd0;
    end else begin
      state_r <= state_s;
      imem_en <= accept_s;
      done    <= capture_s;
      busy    <= accept_s || (state_r == WAIT);
      if (accept_s) begin
        imem_addr <= target_s;
        target_r  <= target_s;
        cnt_r     <= LAT;
      end else if (state_r == WAIT && !capture_s) begin
        cnt_r <= cnt_r - 3'd1;
      end
      if (capture_s) begin
        command    <= imem_data;
        pc         <= target_r;
        first_r    <= 1'b0;
        inst_count <= inst_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: directed scenarios plus randomized fetches checked against a
// PC/count reference model and a fixed-latency memory responder.
module tb_fetch;

  localparam int          L     = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rstn;
  logic        enable;
  logic        jump;
  logic [31:0] jump_addr;
  logic        done, busy, imem_en;
  logic [31:0] pc, command, inst_count, imem_addr;
  logic [31:0] imem_data = 32'd0;

  logic        done1, busy1, en1, done4, busy4, en4;
  logic [31:0] pc1, cmd1, cnt1, addr1, pc4, cmd4, cnt4, addr4;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_pc, exp_cmd, exp_cnt;
  logic        exp_first;

  always #5 clk = ~clk;

  fetch #(.RESET_PC(RPC), .MEM_LATENCY(L)) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .jump(jump), .jump_addr(jump_addr),
    .done(done), .busy(busy), .pc(pc), .command(command), .inst_count(inst_count),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_data(imem_data));

  fetch #(.RESET_PC(32'h0000_0100), .MEM_LATENCY(1)) dut_l1 (
    .clk(clk), .rstn(rstn), .enable(enable), .jump(jump), .jump_addr(jump_addr),
    .done(done1), .busy(busy1), .pc(pc1), .command(cmd1), .inst_count(cnt1),
    .imem_en(en1), .imem_addr(addr1), .imem_data(imem_data));

  fetch #(.RESET_PC(32'h0000_0100), .MEM_LATENCY(4)) dut_l4 (
    .clk(clk), .rstn(rstn), .enable(enable), .jump(jump), .jump_addr(jump_addr),
    .done(done4), .busy(busy4), .pc(pc4), .command(cmd4), .inst_count(cnt4),
    .imem_en(en4), .imem_addr(addr4), .imem_data(imem_data));

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'd0) return 32'h2001_0005;
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_9617;
  endfunction

  // Memory responder for the main DUT: data is valid only in the capture cycle.
  int          lat_q = 0;
  logic [31:0] raddr = 32'd0;
  always @(posedge clk) begin
    if (!rstn) begin
      lat_q = 0;
    end else if (imem_en) begin
      lat_q = L;
      raddr = imem_addr;
    end else if (lat_q > 0) begin
      lat_q = lat_q - 1;
    end
    #1;
    imem_data = (lat_q == 1) ? mem(raddr) : $urandom;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_pc = RPC; exp_cmd = 32'd0; exp_cnt = 32'd0; exp_first = 1'b1;
  endtask

  // One complete fetch from IDLE; noise drives stray enables/jumps while busy.
  task automatic fetch_one(input logic j, input logic [31:0] ja, input bit noise);
    logic [31:0] tgt, pc_d, cmd_d, cnt_d;
    logic        busy_d;
    int          en_seen, done_k;
    tgt = j ? {ja[31:2], 2'b00} : (exp_first ? RPC : exp_pc + 32'd4);
    enable = 1'b1; jump = j; jump_addr = ja;
    @(posedge clk); #1;
    enable = 1'b0; jump = 1'($urandom); jump_addr = $urandom;
    check("imem_en_issue", {31'd0, imem_en}, 32'd1);
    check("imem_addr", imem_addr, tgt);
    check("busy_set", {31'd0, busy}, 32'd1);
    en_seen = 1; done_k = 0;
    pc_d = 32'd0; cmd_d = 32'd0; cnt_d = 32'd0; busy_d = 1'b0;
    for (int k = 1; k <= 12 && done_k == 0; k++) begin
      enable = noise ? 1'($urandom) : 1'b0;
      @(posedge clk); #1;
      if (imem_en) en_seen++;
      if (k == 1) check("pc_hold_wait", pc, exp_pc);
      if (done) begin
        done_k = k; pc_d = pc; cmd_d = command; cnt_d = inst_count; busy_d = busy;
      end
    end
    check("done_latency", 32'(done_k), 32'(L + 1));
    exp_pc = tgt; exp_cmd = mem(tgt); exp_cnt = exp_cnt + 32'd1; exp_first = 1'b0;
    check("pc", pc_d, exp_pc);
    check("command", cmd_d, exp_cmd);
    check("inst_count", cnt_d, exp_cnt);
    check("busy_in_done", {31'd0, busy_d}, 32'd1);
    enable = noise ? 1'b1 : 1'b0;
    @(posedge clk); #1;
    enable = 1'b0;
    check("done_pulse", {31'd0, done}, 32'd0);
    check("busy_clear", {31'd0, busy}, 32'd0);
    check("no_extra_req", {31'd0, imem_en}, 32'd0);
    check("imem_en_count", 32'(en_seen), 32'd1);
    check("imem_addr_hold", imem_addr, tgt);
  endtask

  initial begin
    int          dn, k1, k4;
    logic [31:0] tgt;
    rstn = 1'b0; enable = 1'b0; jump = 1'b0; jump_addr = 32'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_imem_en", {31'd0, imem_en}, 32'd0);
    check("rst_imem_addr", imem_addr, 32'd0);
    check("rst_pc", pc, RPC);
    check("rst_command", command, 32'd0);
    check("rst_count", inst_count, 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    fetch_one(1'b0, 32'd0, 1'b0);
    check("first_cmd", command, 32'h2001_0005);
    repeat (3) fetch_one(1'b0, 32'd0, 1'b0);
    check("seq_pc_c", pc, 32'h0000_000C);
    check("seq_count_4", inst_count, 32'd4);

    fetch_one(1'b1, 32'h0000_0103, 1'b0);
    check("jump_pc_aligned", pc, 32'h0000_0100);
    fetch_one(1'b0, 32'd0, 1'b0);
    check("after_jump_pc", pc, 32'h0000_0104);

    fetch_one(1'b0, 32'd0, 1'b1);
    fetch_one(1'b1, 32'hFFFF_FFFE, 1'b1);
    fetch_one(1'b0, 32'd0, 1'b0);
    check("pc_wrap", pc, 32'd0);

    // Idle without enable: nothing moves.
    repeat (4) @(posedge clk);
    #1;
    check("idle_pc", pc, exp_pc);
    check("idle_cmd", command, exp_cmd);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_en", {31'd0, imem_en}, 32'd0);

    // Reset one edge after the read strobe: the fetch is aborted.
    enable = 1'b1; jump = 1'b0;
    @(posedge clk); #1;
    enable = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_en", {31'd0, imem_en}, 32'd0);
    check("abort_addr", imem_addr, 32'd0);
    check("abort_pc", pc, RPC);
    check("abort_cmd", command, 32'd0);
    check("abort_count", inst_count, 32'd0);
    dn = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    rstn = 1'b1;
    model_reset();
    repeat (4) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    check("abort_no_done", 32'(dn), 32'd0);
    fetch_one(1'b0, 32'd0, 1'b0);
    check("refetch_reset_pc", pc, RPC);

    for (int i = 0; i < 25; i++) begin
      fetch_one(($urandom_range(3) == 0) ? 1'b1 : 1'b0, $urandom, 1'($urandom));
    end

    // Latency of the MEM_LATENCY=1 and =4 builds, all units idle first.
    repeat (8) @(posedge clk);
    #1;
    tgt = exp_pc + 32'd4;
    enable = 1'b1; jump = 1'b0;
    @(posedge clk); #1;
    enable = 1'b0;
    k1 = 0; k4 = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (done1 && k1 == 0) k1 = k;
      if (done4 && k4 == 0) k4 = k;
    end
    check("latency_1", 32'(k1), 32'd2);
    check("latency_4", 32'(k4), 32'd5);
    exp_pc = tgt; exp_cnt = exp_cnt + 32'd1;
    check("lat_main_pc", pc, exp_pc);
    check("lat_main_cmd", command, mem(tgt));
    check("lat_main_count", inst_count, exp_cnt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
